// File: rtl/led_status_conditioner_pkg.sv
// Shared encodings, default timing constants and update-FSM state type for the
// front-panel LED status conditioner.
package led_pkg;

  localparam logic [2:0] ACC_IDLE       = 3'b000;
  localparam logic [2:0] ACC_READ       = 3'b110;
  localparam logic [2:0] ACC_WRITE      = 3'b101;
  localparam int         ACC_ACTIVE_BIT = 2;

  localparam logic [23:0] DEF_HOLD_CYCLES   = 24'd2_400_000;
  localparam logic [23:0] DEF_UPDATE_CYCLES = 24'd1_048_576;

  localparam logic [11:0] PAGE_DEC_MAX = 12'd999;
  localparam logic [3:0]  BCD_LAST_ITER = 4'd11;

  typedef enum logic [1:0] {
    UPD_IDLE = 2'b00,
    UPD_CONV = 2'b01,
    UPD_LOAD = 2'b10
  } upd_state_t;

  function automatic logic [3:0] bcd_add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // Three BCD digits cannot represent anything above 999.
  function automatic logic [11:0] dec_saturate(input logic [11:0] v);
    return (v > PAGE_DEC_MAX) ? PAGE_DEC_MAX : v;
  endfunction

endpackage

// File: rtl/led_status_conditioner_bin2bcd_seq.sv
// Sequential 12-bit double-dabble: one adjust+shift per cycle, 12 iterations,
// start/done handshake, result held on bcd until the next start.
module bin2bcd_seq
  import led_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] bin,
  output logic        done,
  output logic [11:0] bcd
);

  logic [23:0] r_shift;
  logic [3:0]  r_iter;
  logic        r_busy;
  logic        r_done;
  logic [11:0] w_adj;
  logic [23:0] w_shift_nxt;

  assign w_adj = {bcd_add3(r_shift[23:20]), bcd_add3(r_shift[19:16]), bcd_add3(r_shift[15:12])};
  assign w_shift_nxt = {w_adj[10:0], r_shift[11:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= 24'd0;
      r_iter  <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_shift <= w_shift_nxt;
        if (r_iter == BCD_LAST_ITER) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_iter <= 4'd0;
        end else begin
          r_iter <= r_iter + 4'd1;
        end
      end else if (start) begin
        r_shift <= {12'h000, dec_saturate(bin)};
        r_busy  <= 1'b1;
        r_iter  <= 4'd0;
      end
    end
  end

  assign done = r_done;
  assign bcd  = r_shift[23:12];

endmodule

// File: rtl/led_status_conditioner.sv
// Conditions raw emulator status for the front-panel driver: stretches ACCTYPE,
// rate-limits page updates. Decimal page display under LED_STATUS_DECIMAL_PAGE_EN.
module led_status_conditioner
  import led_pkg::*;
#(
  parameter logic [23:0] HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter logic [23:0] UPDATE_CYCLES = DEF_UPDATE_CYCLES
) (
  input  logic        MCLK,
  input  logic        RST,
  input  logic        nWAIT_IN,
  input  logic        ACC_STROBE,
  input  logic [2:0]  ACCTYPE_IN,
  input  logic [11:0] PAGE_IN,
  output logic        nWAIT,
  output logic [2:0]  ACCTYPE,
  output logic [11:0] CURRPAGE,
  output logic        PAGE_UPD
);

  localparam logic [23:0] HOLD_LOAD = HOLD_CYCLES - 24'd1;
  localparam logic [23:0] TICK_LAST = UPDATE_CYCLES - 24'd1;

  logic        r_nwait;
  logic [2:0]  r_acctype;
  logic [23:0] r_hold_cnt;
  logic [23:0] r_tick_cnt;
  logic [11:0] r_page_pending;
  logic        r_pending_valid;
  logic [11:0] r_currpage;
  logic        r_page_upd;
  upd_state_t  r_state;
  upd_state_t  w_state_nxt;
  logic        w_tick;
  logic        w_consume;
  logic        w_load;
  logic [11:0] w_load_val;

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      r_nwait <= 1'b1;
    end else begin
      r_nwait <= nWAIT_IN;
    end
  end

  // A strobe always reloads the hold, so the most recent access wins.
  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      r_acctype  <= ACC_IDLE;
      r_hold_cnt <= 24'd0;
    end else if (ACC_STROBE) begin
      r_acctype  <= ACCTYPE_IN;
      r_hold_cnt <= HOLD_LOAD;
    end else if (r_hold_cnt != 24'd0) begin
      r_hold_cnt <= r_hold_cnt - 24'd1;
    end else begin
      r_acctype  <= ACCTYPE_IN;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      r_tick_cnt <= 24'd0;
    end else if (w_tick) begin
      r_tick_cnt <= 24'd0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 24'd1;
    end
  end

  // A strobe coinciding with a consume refills the slot after the old value is taken.
  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      r_page_pending  <= 12'h000;
      r_pending_valid <= 1'b0;
    end else if (ACC_STROBE) begin
      r_page_pending  <= PAGE_IN;
      r_pending_valid <= 1'b1;
    end else if (w_consume) begin
      r_pending_valid <= 1'b0;
    end
  end

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      r_state <= UPD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef LED_STATUS_DECIMAL_PAGE_EN
  logic        w_conv_done;
  logic [11:0] w_bcd;

  bin2bcd_seq u_bin2bcd (
    .clk   (MCLK),
    .rst   (RST),
    .start (w_consume),
    .bin   (r_page_pending),
    .done  (w_conv_done),
    .bcd   (w_bcd)
  );

  assign w_load_val = w_bcd;
`else
  logic [11:0] r_consumed;

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      r_consumed <= 12'h000;
    end else if (w_consume) begin
      r_consumed <= r_page_pending;
    end
  end

  assign w_load_val = r_consumed;
`endif

  // Ticks are only honoured in IDLE, so a tick during conversion leaves pending data alone.
  always_comb begin
    w_state_nxt = r_state;
    w_consume   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      UPD_IDLE: begin
        if (w_tick && r_pending_valid) begin
          w_consume = 1'b1;
`ifdef LED_STATUS_DECIMAL_PAGE_EN
          w_state_nxt = UPD_CONV;
`else
          w_state_nxt = UPD_LOAD;
`endif
        end else begin
          w_consume   = 1'b0;
          w_state_nxt = UPD_IDLE;
        end
      end
      UPD_CONV: begin
`ifdef LED_STATUS_DECIMAL_PAGE_EN
        if (w_conv_done) begin
          w_state_nxt = UPD_LOAD;
        end else begin
          w_state_nxt = UPD_CONV;
        end
`else
        w_state_nxt = UPD_IDLE;
`endif
      end
      UPD_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = UPD_IDLE;
      end
      default: begin
        w_state_nxt = UPD_IDLE;
      end
    endcase
  end

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      r_currpage <= 12'h000;
      r_page_upd <= 1'b0;
    end else begin
      r_page_upd <= 1'b0;
      if (w_load) begin
        r_currpage <= w_load_val;
        r_page_upd <= (w_load_val != r_currpage);
      end
    end
  end

  assign nWAIT    = r_nwait;
  assign ACCTYPE  = r_acctype;
  assign CURRPAGE = r_currpage;
  assign PAGE_UPD = r_page_upd;

endmodule
